// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM control unit for the multi-cycle RV32I core.
// Sequences RST/IF/ID/EX/MEM/WB, traps on illegal instructions and on memory
// timeouts (TRAP is sticky until reset).
// Optional build macro CTRL_PERF_CNT_EN enables cycle_cnt/instret_cnt; without
// it both ports read 0.
//
// Handshake: imem_req/dmem_req stay high while the FSM waits in IF/MEM; a
// transfer completes in the cycle where req && ready. A ready seen while the
// matching req is low is ignored. All requests drop immediately on rst_n low.
module multicycle_ctrl #(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         inst,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          npc_op,
  output logic                s_npc_offset,
  output logic                s_alua_pc,
  output logic                s_alub_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          ext_op,
  output logic [1:0]          s_rf_wsel,
  output logic                rf_we,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [2:0]          dmem_size,
  output logic                halted,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instret_cnt,
  output logic [2:0]          dbg_state
);
  typedef enum logic [2:0] {S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0), ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2), ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4), ALU_SLL = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(6), ALU_SRA = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(8), ALU_SLTU = ALU_OP_W'(9);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef struct packed {
    logic [1:0]          npc_op;
    logic                npc_off;
    logic                alua_pc;
    logic                alub_imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          ext_op;
    logic [1:0]          rf_wsel;
    logic                rf_wr;
    logic                mem;
    logic                store;
    logic [2:0]          funct3;
  } dec_t;

  state_t        state, state_n;
  dec_t          dec_d, dec_q;
  logic          illegal;
  logic [TW-1:0] wait_cnt;
  logic          waiting, timeout;
  logic          trap_set;
  logic [1:0]    cause_n, cause_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       f7_ok;
  logic       unused_inst_bits;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign f7_ok  = (funct7 == 7'h00) || (funct7 == 7'h20);
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  // funct3 -> ALU op shared by R-type and I-type ALU instructions.
  function automatic logic [ALU_OP_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction decode; only sampled into dec_q at the end of ID.
  always_comb begin
    dec_d        = '0;
    dec_d.funct3 = funct3;
    dec_d.alu_op = ALU_ADD;
    illegal      = 1'b0;
    case (opcode)
      OP_R: begin
        dec_d.alu_op = alu_from_f3(funct3, funct7[5]);
        dec_d.rf_wr  = 1'b1;
        illegal      = !f7_ok;
      end
      OP_I: begin
        dec_d.alu_op   = alu_from_f3(funct3, funct7[5] && (funct3 == 3'b101));
        dec_d.alub_imm = 1'b1;
        dec_d.ext_op   = 3'd1;
        dec_d.rf_wr    = 1'b1;
        // only the shift-immediates carry a funct7 field
        if (funct3 == 3'b001 || funct3 == 3'b101) illegal = !f7_ok;
      end
      OP_LOAD: begin
        dec_d.mem      = 1'b1;
        dec_d.alub_imm = 1'b1;
        dec_d.ext_op   = 3'd1;
        dec_d.rf_wsel  = 2'd1;
        dec_d.rf_wr    = 1'b1;
      end
      OP_STORE: begin
        dec_d.mem      = 1'b1;
        dec_d.store    = 1'b1;
        dec_d.alub_imm = 1'b1;
        dec_d.ext_op   = 3'd2;
      end
      OP_BRANCH: begin
        dec_d.npc_op = 2'd1;
        dec_d.ext_op = 3'd3;
        case (funct3[2:1])
          2'b10:   dec_d.alu_op = ALU_SLT;
          2'b11:   dec_d.alu_op = ALU_SLTU;
          default: dec_d.alu_op = ALU_SUB;
        endcase
      end
      OP_JAL: begin
        dec_d.npc_op  = 2'd2;
        dec_d.ext_op  = 3'd5;
        dec_d.rf_wsel = 2'd2;
        dec_d.rf_wr   = 1'b1;
      end
      OP_JALR: begin
        dec_d.npc_op   = 2'd2;
        dec_d.npc_off  = 1'b1;
        dec_d.ext_op   = 3'd1;
        dec_d.alub_imm = 1'b1;
        dec_d.rf_wsel  = 2'd2;
        dec_d.rf_wr    = 1'b1;
      end
      OP_LUI: begin
        dec_d.ext_op  = 3'd4;
        dec_d.rf_wsel = 2'd3;
        dec_d.rf_wr   = 1'b1;
      end
      OP_AUIPC: begin
        dec_d.ext_op   = 3'd4;
        dec_d.alua_pc  = 1'b1;
        dec_d.alub_imm = 1'b1;
        dec_d.rf_wr    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign waiting = ((state == S_IF) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
  assign timeout = (MEM_TIMEOUT > 0) && (wait_cnt == TO_LAST);

  // Next state and per-stage control outputs (Moore fields, Mealy strobes on ready).
  always_comb begin
    state_n      = state;
    trap_set     = 1'b0;
    cause_n      = 2'd0;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    npc_op       = 2'd0;
    s_npc_offset = 1'b0;
    s_alua_pc    = 1'b0;
    s_alub_sel   = 1'b0;
    alu_op       = '0;
    ext_op       = 3'd0;
    s_rf_wsel    = 2'd0;
    rf_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_size    = 3'd0;
    halted       = 1'b0;
    // datapath selects follow the held decode from EX through WB
    if (state == S_EX || state == S_MEM || state == S_WB) begin
      npc_op       = dec_q.npc_op;
      s_npc_offset = dec_q.npc_off;
      s_alua_pc    = dec_q.alua_pc;
      s_alub_sel   = dec_q.alub_imm;
      alu_op       = dec_q.alu_op;
      ext_op       = dec_q.ext_op;
      s_rf_wsel    = dec_q.rf_wsel;
    end
    case (state)
      S_RST: state_n = S_IF;
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_n = S_ID;
        end else if (timeout) begin
          trap_set = 1'b1;
          cause_n  = 2'd2;
          state_n  = S_TRAP;
        end
      end
      S_ID: begin
        if (illegal) begin
          trap_set = 1'b1;
          cause_n  = 2'd1;
          state_n  = S_TRAP;
        end else begin
          state_n = S_EX;
        end
      end
      S_EX: state_n = dec_q.mem ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = dec_q.store;
        dmem_size = dec_q.funct3;
        if (dmem_ready) begin
          pc_we   = dec_q.store;
          state_n = dec_q.store ? S_IF : S_WB;
        end else if (timeout) begin
          trap_set = 1'b1;
          cause_n  = 2'd3;
          state_n  = S_TRAP;
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        rf_we   = dec_q.rf_wr;
        state_n = S_IF;
      end
      S_TRAP: halted = 1'b1;
      default: state_n = S_RST;
    endcase
  end

  // State, held decode, wait counter and sticky trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      dec_q    <= '0;
      wait_cnt <= '0;
      cause_q  <= 2'd0;
    end else begin
      state <= state_n;
      if (state == S_ID) dec_q <= dec_d;
      if (waiting) wait_cnt <= wait_cnt + TW'(1);
      else         wait_cnt <= '0;
      if (trap_set) cause_q <= cause_n;
    end
  end

  assign trap_cause = cause_q;
  assign dbg_state  = state;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  // Free-running cycle count (frozen once trapped) and retire count on pc_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state != S_TRAP) cyc_q <= cyc_q + CNT_W'(1);
      if (pc_we)           ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
